// File: rtl/frame_serial_router.sv
// frame_serial_router: parses E0E0,E0E0 / channel / 1-8 data words / CRC-16 / 0E0E,0E0E frames
// from a 16-bit word stream. CRC-checked payloads are Gray-coded, queued as whole frames in a
// FIFO_DEPTH-entry FIFO and shifted out MSB-first on one of eight serial channels.
// Ports: clk_in, rst (sync, active-high), data_in[15:0]; data_out_ch1..8 / data_vld_ch1..8
// serial outputs; fifo_empty / fifo_full FIFO status; crc_valid_o (first bit), crc_err pulses.
// Latency: result two clocks after the last trailer word, first serial bit two clocks after push.
// Backpressure: none on the input; a matching frame arriving with the FIFO full is dropped.
module frame_serial_router #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] data_in,
  output logic        data_out_ch1,
  output logic        data_out_ch2,
  output logic        data_out_ch3,
  output logic        data_out_ch4,
  output logic        data_out_ch5,
  output logic        data_out_ch6,
  output logic        data_out_ch7,
  output logic        data_out_ch8,
  output logic        data_vld_ch1,
  output logic        data_vld_ch2,
  output logic        data_vld_ch3,
  output logic        data_vld_ch4,
  output logic        data_vld_ch5,
  output logic        data_vld_ch6,
  output logic        data_vld_ch7,
  output logic        data_vld_ch8,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        crc_valid_o,
  output logic        crc_err
);

  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] HDR_WORD = 16'hE0E0;
  localparam logic [15:0] TRL_WORD = 16'h0E0E;

  typedef enum logic [1:0] {HUNT, CHAN, PAYLOAD, CHECK} state_t;

  typedef struct packed {
    logic [2:0]   ch;
    logic [3:0]   len;
    logic [127:0] gray;
  } entry_t;

  // CRC-16/0x1021 over a 128-bit value, MSB first; leading zeros leave a zero CRC untouched.
  function automatic logic [15:0] crc16_128(input logic [127:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int b = 127; b >= 0; b--) begin
      fb = c[15] ^ d[b];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // ---------------- parser ----------------
  state_t      state, state_nxt;
  logic [15:0] prev_word;
  logic [15:0] hist [11];   // hist[0] = newest payload word
  logic [3:0]  k;           // payload words seen, including CRC and trailer
  logic [3:0]  k_inc;
  logic        discard;
  logic [2:0]  chan, chan_idx;
  logic        chan_ok, is_trailer;

  assign k_inc      = k + 4'd1;
  assign chan_ok    = (data_in[15:8] == 8'h00) && $onehot(data_in[7:0]);
  // k != 0 keeps the channel word from pairing with the first payload word
  assign is_trailer = (k != 4'd0) && (prev_word == TRL_WORD) && (data_in == TRL_WORD);

  always_comb begin
    chan_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (data_in[i]) chan_idx = 3'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (prev_word == HDR_WORD && data_in == HDR_WORD) state_nxt = CHAN;
      CHAN:    state_nxt = PAYLOAD;
      PAYLOAD: begin
        if (k_inc > 4'd11)   state_nxt = HUNT;  // oversize: silent abort
        else if (is_trailer) state_nxt = (discard || k_inc < 4'd4) ? HUNT : CHECK;
      end
      CHECK:   state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= HUNT;
      prev_word <= 16'h0000;
      k         <= 4'd0;
      discard   <= 1'b0;
      chan      <= 3'd0;
      for (int i = 0; i < 11; i++) hist[i] <= 16'h0000;
    end else begin
      state     <= state_nxt;
      prev_word <= data_in;
      if (state == CHAN) begin
        k       <= 4'd0;
        discard <= !chan_ok;
        chan    <= chan_idx;
      end
      if (state == PAYLOAD) begin
        k       <= k_inc;
        hist[0] <= data_in;
        for (int i = 1; i < 11; i++) hist[i] <= hist[i-1];
      end
    end
  end

  // ---------------- CRC check (CHECK state) ----------------
  // In CHECK: hist[0..1] trailer, hist[2] CRC, hist[3..] data words, newest = least significant.
  logic [3:0]   len;
  logic [127:0] data_vec, gray_vec;
  logic         crc_ok, check_now, push, pop;

  assign len = k - 4'd3;

  always_comb begin
    data_vec = '0;
    for (int i = 0; i < 8; i++) begin
      data_vec[16*i +: 16] = (4'(i) < len) ? hist[3+i] : 16'h0000;
    end
  end

  assign gray_vec  = data_vec ^ (data_vec >> 1);
  assign crc_ok    = (crc16_128(data_vec) == hist[2]);
  assign check_now = (state == CHECK);
  assign push      = check_now && crc_ok && !fifo_full;

  always_ff @(posedge clk_in) begin
    if (rst) crc_err <= 1'b0;
    else     crc_err <= check_now && !crc_ok;
  end

  // ---------------- frame FIFO ----------------
  entry_t        mem [FIFO_DEPTH];
  entry_t        rd_entry;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;

  assign rd_entry = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= '{ch: chan, len: len, gray: gray_vec};
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      fifo_empty <= (count_nxt == '0);
      fifo_full  <= (count_nxt == (AW+1)'(FIFO_DEPTH));
    end
  end

  // ---------------- serializer ----------------
  logic         busy, first;
  logic [127:0] sr;
  logic [7:0]   bits_left;
  logic [2:0]   out_ch;
  logic [7:0]   vld_vec, out_vec;

  // Popping only from idle guarantees at least one idle cycle between frames.
  assign pop = !busy && !fifo_empty;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      busy      <= 1'b0;
      first     <= 1'b0;
      sr        <= '0;
      bits_left <= 8'd0;
      out_ch    <= 3'd0;
    end else if (pop) begin
      busy      <= 1'b1;
      first     <= 1'b1;
      // left-align so the frame's MSB sits at sr[127]
      sr        <= rd_entry.gray << (8'd128 - {rd_entry.len, 4'b0000});
      bits_left <= {rd_entry.len, 4'b0000};
      out_ch    <= rd_entry.ch;
    end else if (busy) begin
      first     <= 1'b0;
      sr        <= sr << 1;
      bits_left <= bits_left - 8'd1;
      if (bits_left == 8'd1) busy <= 1'b0;
    end
  end

  always_comb begin
    vld_vec = 8'h00;
    out_vec = 8'h00;
    if (busy) begin
      vld_vec[out_ch] = 1'b1;
      out_vec[out_ch] = sr[127];
    end
  end

  assign crc_valid_o  = first;

  assign data_out_ch1 = out_vec[0];
  assign data_out_ch2 = out_vec[1];
  assign data_out_ch3 = out_vec[2];
  assign data_out_ch4 = out_vec[3];
  assign data_out_ch5 = out_vec[4];
  assign data_out_ch6 = out_vec[5];
  assign data_out_ch7 = out_vec[6];
  assign data_out_ch8 = out_vec[7];
  assign data_vld_ch1 = vld_vec[0];
  assign data_vld_ch2 = vld_vec[1];
  assign data_vld_ch3 = vld_vec[2];
  assign data_vld_ch4 = vld_vec[3];
  assign data_vld_ch5 = vld_vec[4];
  assign data_vld_ch6 = vld_vec[5];
  assign data_vld_ch7 = vld_vec[6];
  assign data_vld_ch8 = vld_vec[7];

endmodule

// File: tb/tb_frame_serial_router.sv
// Testbench for frame_serial_router: directed frames, scoreboard of expected serial frames.
module tb_frame_serial_router;

  logic        clk_in = 1'b0;
  logic        rst    = 1'b1;
  logic [15:0] data_in = 16'h0000;
  logic        data_out_ch1, data_out_ch2, data_out_ch3, data_out_ch4;
  logic        data_out_ch5, data_out_ch6, data_out_ch7, data_out_ch8;
  logic        data_vld_ch1, data_vld_ch2, data_vld_ch3, data_vld_ch4;
  logic        data_vld_ch5, data_vld_ch6, data_vld_ch7, data_vld_ch8;
  logic        fifo_empty, fifo_full, crc_valid_o, crc_err;

  always #5 clk_in = ~clk_in;

  frame_serial_router #(.FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .rst(rst), .data_in(data_in),
    .data_out_ch1(data_out_ch1), .data_out_ch2(data_out_ch2),
    .data_out_ch3(data_out_ch3), .data_out_ch4(data_out_ch4),
    .data_out_ch5(data_out_ch5), .data_out_ch6(data_out_ch6),
    .data_out_ch7(data_out_ch7), .data_out_ch8(data_out_ch8),
    .data_vld_ch1(data_vld_ch1), .data_vld_ch2(data_vld_ch2),
    .data_vld_ch3(data_vld_ch3), .data_vld_ch4(data_vld_ch4),
    .data_vld_ch5(data_vld_ch5), .data_vld_ch6(data_vld_ch6),
    .data_vld_ch7(data_vld_ch7), .data_vld_ch8(data_vld_ch8),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .crc_valid_o(crc_valid_o), .crc_err(crc_err)
  );

  wire [7:0] vld  = {data_vld_ch8, data_vld_ch7, data_vld_ch6, data_vld_ch5,
                     data_vld_ch4, data_vld_ch3, data_vld_ch2, data_vld_ch1};
  wire [7:0] dout = {data_out_ch8, data_out_ch7, data_out_ch6, data_out_ch5,
                     data_out_ch4, data_out_ch3, data_out_ch2, data_out_ch1};

  typedef struct {
    logic [7:0]   ch;
    logic [127:0] bits;
    int           nbits;
    bit           cv;
  } obs_t;

  typedef struct {
    logic [7:0]   ch;
    logic [127:0] gray;
    int           nbits;
  } exp_t;

  exp_t        exp_q[$];
  obs_t        obs_a [32];
  int          obs_n = 0;       // written by monitor only
  int          obs_rd = 0;      // written by stimulus only
  int          checks = 0;
  int          errors = 0;
  int          err_pulses = 0;
  int          cv_pulses = 0;
  int          stray = 0;
  bit          full_seen = 1'b0;
  bit          in_frame = 1'b0;
  logic        prev_err = 1'b0;
  obs_t        cur;
  logic [15:0] pay [16];

  // ---------------- output monitor ----------------
  always @(negedge clk_in) begin
    if (rst) begin
      in_frame = 1'b0;          // reset aborts a frame in flight
      prev_err = 1'b0;
    end else begin
      if (crc_err) begin
        err_pulses++;
        if (prev_err) stray++;  // crc_err must be a single-cycle pulse
      end
      prev_err = crc_err;
      if (crc_valid_o) cv_pulses++;
      if (fifo_full) full_seen = 1'b1;
      if ((dout & ~vld) != 8'h00) stray++;
      if (vld != 8'h00) begin
        if (!$onehot(vld)) stray++;
        if (!in_frame) begin
          in_frame  = 1'b1;
          cur.ch    = vld;
          cur.bits  = '0;
          cur.nbits = 0;
          cur.cv    = crc_valid_o;
        end else if (vld != cur.ch || crc_valid_o) begin
          stray++;
        end
        cur.bits = {cur.bits[126:0], |(dout & vld)};
        cur.nbits++;
      end else begin
        if (crc_valid_o) stray++;
        if (in_frame) begin
          in_frame = 1'b0;
          if (obs_n < 32) obs_a[obs_n] = cur;
          obs_n++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_in);
      data_in = 16'h0000;
    end
  endtask

  task automatic send(input logic [15:0] w);
    @(negedge clk_in);
    data_in = w;
  endtask

  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 0; i < n; i++) begin
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ pay[i][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  function automatic logic [127:0] gray_model(input int n);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < n; i++) d = {d[111:0], pay[i]};
    return d ^ (d >> 1);
  endfunction

  task automatic send_frame(input logic [15:0] chw, input int n, input bit bad_crc);
    logic [15:0] c;
    c = bad_crc ? 16'hFFFF : crc_model(n);
    send(16'hE0E0);
    send(16'hE0E0);
    send(chw);
    for (int i = 0; i < n; i++) send(pay[i]);
    send(c);
    send(16'h0E0E);
    send(16'h0E0E);
    send(16'h0000);
  endtask

  task automatic expect_frame(input int ch, input logic [127:0] g, input int n);
    exp_t e;
    e.ch    = 8'(1 << ch);
    e.gray  = g;
    e.nbits = 16 * n;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    exp_t e;
    obs_t o;
    int   waited;
    while (exp_q.size() != 0) begin
      waited = 0;
      while (obs_rd >= obs_n && waited < budget) begin
        @(negedge clk_in);
        waited++;
      end
      if (obs_rd >= obs_n) begin
        chk("frame_timeout", 128'(obs_n - obs_rd), 128'd1);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_a[obs_rd];
        obs_rd++;
        chk("frame_channel", 128'(o.ch), 128'(e.ch));
        chk("frame_bits", 128'(o.nbits), 128'(e.nbits));
        chk("frame_data", o.bits, e.gray);
        chk("frame_crc_valid", 128'(o.cv), 128'd1);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e0, c0, o0, n;

    // reset state
    rst = 1'b1;
    tick(3);
    chk("reset_vld", 128'(vld), 128'h0);
    chk("reset_dout", 128'(dout), 128'h0);
    chk("reset_crc_valid", 128'(crc_valid_o), 128'h0);
    chk("reset_crc_err", 128'(crc_err), 128'h0);
    chk("reset_fifo_empty", 128'(fifo_empty), 128'h1);
    chk("reset_fifo_full", 128'(fifo_full), 128'h0);
    @(negedge clk_in);
    rst = 1'b0;
    tick(2);

    // ch1 A55A, then ch3 1234 parsed while ch1 is still shifting
    pay[0] = 16'hA55A;
    send_frame(16'h0001, 1, 1'b0);
    expect_frame(0, 128'hF7F7, 1);
    pay[0] = 16'h1234;
    send_frame(16'h0004, 1, 1'b0);
    expect_frame(2, 128'h1B2E, 1);
    chk("overlap_shifting_ch1", 128'(vld), 128'h01);
    drain(300);

    // full 128-bit frame on ch2, FIFO empty status and first-bit latency
    pay[0] = 16'h0123; pay[1] = 16'h4567; pay[2] = 16'h89AB; pay[3] = 16'hCDEF;
    pay[4] = 16'hFEDC; pay[5] = 16'hBA98; pay[6] = 16'h7654; pay[7] = 16'h3210;
    send_frame(16'h0002, 8, 1'b0);
    expect_frame(1, gray_model(8), 8);
    n = 0;
    while (fifo_empty && n < 10) begin @(negedge clk_in); n++; end
    chk("fifo_empty_deassert", 128'(fifo_empty), 128'h0);
    n = 0;
    while (vld == 8'h00 && n < 3) begin @(negedge clk_in); n++; end
    chk("first_bit_latency", 128'(vld), 128'h02);
    n = 0;
    while (!fifo_empty && n < 10) begin @(negedge clk_in); n++; end
    chk("fifo_empty_reassert", 128'(fifo_empty), 128'h1);
    drain(400);

    // bad CRC
    e0 = err_pulses; c0 = cv_pulses; o0 = obs_n;
    pay[0] = 16'h1234;
    send_frame(16'h0001, 1, 1'b1);
    tick(30);
    chk("crc_err_pulse", 128'(err_pulses - e0), 128'd1);
    chk("crc_err_no_valid", 128'(cv_pulses - c0), 128'd0);
    chk("crc_err_no_output", 128'(obs_n - o0), 128'd0);

    // oversize frame, then a valid frame on ch8
    e0 = err_pulses; o0 = obs_n;
    for (int i = 0; i < 16; i++) pay[i] = 16'hAAAA;
    send_frame(16'h0020, 16, 1'b0);
    tick(30);
    chk("oversize_no_err", 128'(err_pulses - e0), 128'd0);
    chk("oversize_no_output", 128'(obs_n - o0), 128'd0);
    pay[0] = 16'hBEEF; pay[1] = 16'h0001; pay[2] = 16'h8000;
    send_frame(16'h0080, 3, 1'b0);
    expect_frame(7, gray_model(3), 3);
    drain(300);

    // silently dropped: two-hot channel, high-byte channel, zero data words
    e0 = err_pulses; o0 = obs_n;
    pay[0] = 16'h5555;
    send_frame(16'h0003, 1, 1'b0);
    send_frame(16'h0101, 1, 1'b0);
    send_frame(16'h0001, 0, 1'b0);
    tick(40);
    chk("dropped_no_err", 128'(err_pulses - e0), 128'd0);
    chk("dropped_no_output", 128'(obs_n - o0), 128'd0);

    // one frame to occupy the serializer, then five more: FIFO fills, last one is dropped
    chk("full_not_seen_yet", 128'(full_seen), 128'h0);
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 8; i++) pay[i] = 16'(f * 4096 + i * 17 + 5);
      send_frame(16'(1 << (f % 8)), 8, 1'b0);
      if (f < 5) expect_frame(f % 8, gray_model(8), 8);
    end
    chk("fifo_full_seen", 128'(full_seen), 128'h1);
    drain(1200);
    tick(300);
    chk("overflow_frame_dropped", 128'(obs_n - obs_rd), 128'd0);
    chk("fifo_empty_after_drain", 128'(fifo_empty), 128'h1);
    chk("fifo_full_after_drain", 128'(fifo_full), 128'h0);
    chk("protocol_stray", 128'(stray), 128'd0);
    chk("crc_valid_count", 128'(cv_pulses), 128'(obs_n));

    // reset in the middle of a shift aborts the frame
    for (int i = 0; i < 8; i++) pay[i] = 16'(16'h1111 * (i + 1));
    send_frame(16'h0010, 8, 1'b0);
    n = 0;
    while (vld == 8'h00 && n < 10) begin @(negedge clk_in); n++; end
    chk("mid_reset_shift_started", 128'(vld), 128'h10);
    tick(5);
    rst = 1'b1;
    tick(2);
    chk("mid_reset_vld", 128'(vld), 128'h0);
    chk("mid_reset_fifo_empty", 128'(fifo_empty), 128'h1);
    rst = 1'b0;
    tick(200);
    chk("mid_reset_no_output", 128'(obs_n - obs_rd), 128'd0);
    pay[0] = 16'h0F0F;
    send_frame(16'h0008, 1, 1'b0);
    expect_frame(3, gray_model(1), 1);
    drain(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
